gcd_stein_param: RTL and testbench

- Parametrised successor to the team's 8-bit GCD engine.
- Computes GCD of two unsigned WIDTH-bit operands using the binary (Stein) algorithm: shifts, compares and subtracts only, no divider.
- Adds an explicit busy indication, defined zero-operand handling, a guaranteed latency bound and a held result.
- Sits as a standalone arithmetic peripheral, loaded by a controller or testbench via a single-cycle ld strobe.

---
 rtl/gcd_stein_param.sv | 140 ++++++++++++++
 tb/tb_gcd_stein_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_stein_param.sv
// Purpose: binary (Stein) GCD of two unsigned WIDTH-bit operands, loaded by a one-cycle ld strobe.
// Latency: 3 to 3*WIDTH+4 cycles from the ld-accept edge to the cycle in which done pulses.
// Backpressure: none; ld is accepted only while busy=0 and ignored otherwise; res holds until the next FIN.
// Optional feature macro: GCD_ITER_CNT_EN adds the iter_cnt busy-cycle counter output.
module gcd_stein_param #(
    parameter int WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            resetb,
    input  logic                            ld,
    input  logic [WIDTH-1:0]                U,
    input  logic [WIDTH-1:0]                V,
    output logic                            busy,
    output logic [WIDTH-1:0]                res,
`ifdef GCD_ITER_CNT_EN
    output logic [$clog2(3*WIDTH+5)-1:0]    iter_cnt,
`endif
    output logic                            done
);

    localparam int KW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ZCHK   = 3'd1,
        STRIP  = 3'd2,
        MKODD  = 3'd3,
        REDUCE = 3'd4,
        FIN    = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  u;
    logic [WIDTH-1:0]  v;
    logic [WIDTH-1:0]  r;
    logic [KW-1:0]     k;

    // Accept is only possible when not busy; shared by the FSM and the optional counter.
    logic accept;
    assign accept = ld && ((state == IDLE) || (state == DONE));

    // Main FSM: operand capture, zero check, common-power strip, odd-making and subtract/shift reduction.
    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            res   <= '0;
            u     <= '0;
            v     <= '0;
            r     <= '0;
            k     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        u     <= U;
                        v     <= V;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= ZCHK;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ZCHK: begin
                    // Zero operands short-circuit: gcd(0,x)=x, gcd(0,0)=0.
                    if (u == '0) begin
                        r     <= v;
                        state <= FIN;
                    end else if (v == '0) begin
                        r     <= u;
                        state <= FIN;
                    end else begin
                        state <= STRIP;
                    end
                end
                STRIP: begin
                    // Remove the common power of two, remembered in k.
                    if (!u[0] && !v[0]) begin
                        u <= u >> 1;
                        v <= v >> 1;
                        k <= k + KW'(1);
                    end else begin
                        state <= MKODD;
                    end
                end
                MKODD: begin
                    if (!u[0]) begin
                        u <= u >> 1;
                    end else begin
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
                    // u stays odd here; subtract only in the non-negative direction.
                    if (v == '0) begin
                        r     <= u;
                        state <= FIN;
                    end else if (!v[0]) begin
                        v <= v >> 1;
                    end else if (u > v) begin
                        u <= v;
                        v <= u - v;
                    end else begin
                        v <= v - u;
                    end
                end
                FIN: begin
                    // Result never exceeds max(U,V), so the shift cannot overflow.
                    res   <= r << k;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef GCD_ITER_CNT_EN
    // Busy-cycle counter: cleared on accept, counts ZCHK..FIN, then holds with res.
    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            iter_cnt <= '0;
        end else if (accept) begin
            iter_cnt <= '0;
        end else if ((state != IDLE) && (state != DONE)) begin
            iter_cnt <= iter_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_stein_param.sv
// Purpose: self-checking bench for gcd_stein_param at WIDTH=8 and WIDTH=16 using an expected-result queue.
// Latency: each operation is bounded by 3*WIDTH+4 cycles; an expired bound is reported as a failure.
// Backpressure: ld is driven only where the scenario calls for it, including while busy and in the done cycle.
module tb_gcd_stein_param;

    logic        clk = 1'b0;
    logic        resetb;
    logic        ld8, ld16;
    logic [7:0]  u8, v8, res8;
    logic [15:0] u16, v16, res16;
    logic        busy8, done8, busy16, done16;
`ifdef GCD_ITER_CNT_EN
    logic [$clog2(3*8+5)-1:0]  iter8;
    logic [$clog2(3*16+5)-1:0] iter16;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp8_q[$];
    logic [15:0] exp16_q[$];

    always #5 clk = ~clk;

    gcd_stein_param #(.WIDTH(8)) dut8 (
        .clk(clk), .resetb(resetb), .ld(ld8), .U(u8), .V(v8),
        .busy(busy8), .res(res8),
`ifdef GCD_ITER_CNT_EN
        .iter_cnt(iter8),
`endif
        .done(done8)
    );

    gcd_stein_param #(.WIDTH(16)) dut16 (
        .clk(clk), .resetb(resetb), .ld(ld16), .U(u16), .V(v16),
        .busy(busy16), .res(res16),
`ifdef GCD_ITER_CNT_EN
        .iter_cnt(iter16),
`endif
        .done(done16)
    );

    function automatic int unsigned gcd_ref(input int unsigned a, input int unsigned b);
        int unsigned x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Called at a negedge: one-cycle ld pulse, returns at the following negedge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        ld8 = 1'b1; u8 = a; v8 = b;
        @(negedge clk);
        ld8 = 1'b0;
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b);
        ld16 = 1'b1; u16 = a; v16 = b;
        @(negedge clk);
        ld16 = 1'b0;
    endtask

    // Entry negedge is latency 1; returns at the negedge where done is seen (or the budget runs out).
    task automatic wait8(output int lat, output int bc, output bit to);
        int n;
        n = 0; bc = 0;
        while (done8 !== 1'b1 && n < 40) begin
            if (busy8 === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
        to  = (done8 !== 1'b1);
        lat = n + 1;
    endtask

    task automatic wait16(output int lat, output int bc, output bit to);
        int n;
        n = 0; bc = 0;
        while (done16 !== 1'b1 && n < 70) begin
            if (busy16 === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
        to  = (done16 !== 1'b1);
        lat = n + 1;
    endtask

    task automatic test_reset;
        resetb = 1'b1;
        ld8 = 1'b0; ld16 = 1'b0; u8 = '0; v8 = '0; u16 = '0; v16 = '0;
        repeat (2) @(negedge clk);
        resetb = 1'b0;
        @(negedge clk);
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %0b expected 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done8: got %0b expected 0", done8); end
        checks++; if (res8 !== 8'd0) begin errors++; $display("FAIL reset_res8: got %0d expected 0", res8); end
        checks++; if (res16 !== 16'd0) begin errors++; $display("FAIL reset_res16: got %0d expected 0", res16); end
`ifdef GCD_ITER_CNT_EN
        checks++; if (iter8 !== '0) begin errors++; $display("FAIL reset_iter8: got %0d expected 0", iter8); end
`endif
    endtask

    task automatic test_basic;
        int lat, bc; bit to;
        logic [7:0] e;
        exp8_q.push_back(8'd6);
        start8(8'd48, 8'd18);
        wait8(lat, bc, to);
        e = exp8_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: done not seen, expected within 28 cycles"); end
        checks++; if (res8 !== e) begin errors++; $display("FAIL basic_res: got %0d expected %0d", res8, e); end
        checks++; if (lat < 3 || lat > 28) begin errors++; $display("FAIL basic_latency: got %0d expected 3..28", lat); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %0b expected 0", busy8); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (res8 !== 8'd6) begin errors++; $display("FAIL basic_hold[%0d]: got %0d expected 6", i, res8); end
        end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %0b expected 0", done8); end
    endtask

    task automatic test_zero;
        int lat, bc; bit to;
        logic [7:0] a_t[3];
        logic [7:0] b_t[3];
        logic [7:0] e;
        a_t[0] = 8'd0; b_t[0] = 8'd0;
        a_t[1] = 8'd0; b_t[1] = 8'd37;
        a_t[2] = 8'd200; b_t[2] = 8'd0;
        for (int i = 0; i < 3; i++) begin
            exp8_q.push_back(8'(gcd_ref(a_t[i], b_t[i])));
            start8(a_t[i], b_t[i]);
            wait8(lat, bc, to);
            e = exp8_q.pop_front();
            checks++; if (res8 !== e) begin errors++; $display("FAIL zero_res[%0d]: got %0d expected %0d", i, res8, e); end
            checks++; if (to || lat != 3) begin errors++; $display("FAIL zero_latency[%0d]: got %0d expected 3", i, lat); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc; bit to;
        logic [7:0] e;
        exp8_q.push_back(8'd255);
        start8(8'd255, 8'd255);
        @(negedge clk);
        // Second ld lands while busy and must be ignored.
        start8(8'd12, 8'd8);
        wait8(lat, bc, to);
        e = exp8_q.pop_front();
        checks++; if (to || res8 !== e) begin errors++; $display("FAIL ignore_busy_ld: got %0d expected %0d (timeout=%0b)", res8, e, to); end
        // Third ld presented in the done cycle is accepted.
        exp8_q.push_back(8'd4);
        start8(8'd12, 8'd8);
        wait8(lat, bc, to);
        e = exp8_q.pop_front();
        checks++; if (to || res8 !== e) begin errors++; $display("FAIL ld_in_done_cycle: got %0d expected %0d (timeout=%0b)", res8, e, to); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, bc; bit to, seen;
        logic [7:0] e;
        start8(8'd252, 8'd105);
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        resetb = 1'b0;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %0b expected 0", busy8); end
        checks++; if (res8 !== 8'd0) begin errors++; $display("FAIL midreset_res: got %0d expected 0", res8); end
        seen = 1'b0;
        for (int i = 0; i < 3*8+6; i++) begin
            if (done8 === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen) begin errors++; $display("FAIL midreset_no_done: got done pulse expected none"); end
        exp8_q.push_back(8'(gcd_ref(252, 105)));
        start8(8'd252, 8'd105);
        wait8(lat, bc, to);
        e = exp8_q.pop_front();
        checks++; if (to || res8 !== e) begin errors++; $display("FAIL midreset_rerun: got %0d expected %0d (timeout=%0b)", res8, e, to); end
        @(negedge clk);
    endtask

    task automatic test_width16;
        int lat, bc; bit to;
        logic [15:0] a, b, e;
        exp16_q.push_back(16'd15);
        start16(16'd65535, 16'd4095);
        wait16(lat, bc, to);
        e = exp16_q.pop_front();
        checks++; if (to || res16 !== e) begin errors++; $display("FAIL w16_res: got %0d expected %0d (timeout=%0b)", res16, e, to); end
        checks++; if (lat > 52) begin errors++; $display("FAIL w16_latency: got %0d expected <=52", lat); end
        for (int i = 0; i < 500; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            if (i % 50 == 0) a = 16'd0;
            if (i % 7 == 0) b = 16'($urandom_range(1, 15)) << $urandom_range(0, 6);
            @(negedge clk);
            exp16_q.push_back(16'(gcd_ref(a, b)));
            start16(a, b);
            wait16(lat, bc, to);
            e = exp16_q.pop_front();
            checks++; if (to || res16 !== e) begin errors++; $display("FAIL w16_rand[%0d] gcd(%0d,%0d): got %0d expected %0d", i, a, b, res16, e); end
            checks++; if (lat < 3 || lat > 3*16+4) begin errors++; $display("FAIL w16_bound[%0d]: got %0d expected 3..52", i, lat); end
        end
    endtask

`ifdef GCD_ITER_CNT_EN
    task automatic test_iter_cnt;
        int lat, bc; bit to;
        logic [7:0] e;
        @(negedge clk);
        exp8_q.push_back(8'd32);
        start8(8'd64, 8'd32);
        wait8(lat, bc, to);
        e = exp8_q.pop_front();
        checks++; if (to || res8 !== e) begin errors++; $display("FAIL iter_res: got %0d expected %0d", res8, e); end
        checks++; if (int'(iter8) != bc) begin errors++; $display("FAIL iter_cnt: got %0d expected %0d", iter8, bc); end
        @(negedge clk);
        checks++; if (int'(iter8) != bc) begin errors++; $display("FAIL iter_hold: got %0d expected %0d", iter8, bc); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_zero;
        test_back_to_back;
        test_reset_mid;
        test_width16;
`ifdef GCD_ITER_CNT_EN
        test_iter_cnt;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
